pc_target_lut_rf: RTL and testbench
===================================

// Module: pc_target_lut_rf
// PURPOSE
//  Writable, parametrised successor to the fetch-stage PC/constant lookup table.
//  Holds DEPTH entries of D-bit targets or LDI constants, and a per-entry "defined" bit.
//  After reset (or on reinit), an internal sequencer loads the default program table.
//  At runtime: registered reads for the fetch/decode stage, single-port writes for patching.
// PARAMETERS
//  D      12      target/constant width (bits)
//  A      5       address width
//  DEPTH  2**A    number of entries (must be <= 2**A, >= 23)
// PORTS
//  clk       in   1  system clock, rising edge
//  reset_n   in   1  asynchronous, active-low reset
//  reinit    in   1  1-cycle pulse: reload default table
//  ready     out  1  1 = table usable; 0 = INIT in progress
//  rd_en     in   1  read request
//  rd_addr   in   A  read address
//  rd_data   out  D  registered read data
//  rd_def    out  1  defined bit of the entry that was read
//  rd_valid  out  1  1 cycle after an accepted read
//  wr_en     in   1  write request
//  wr_addr   in   A  write address
//  wr_data   in   D  write data; sets the entry's defined bit
// BEHAVIOUR
//  Reset (async assert): state=INIT, idx=0, ready=0, rd_data=0, rd_def=0, rd_valid=0.
//  Default table (hex, zero-extended or truncated to D):
//   0:000 1:001 2:008 3:010 4:011 5:0FF 6:080 10:009 11:00D 12:010 13:014
//   14:01D 15:025 16:032 17:034 18:041 19:043 20:046 21:049 22:1FF.
//   Every other index: data 0, defined=0. Listed indices: defined=1.
//  FSM INIT:
//   - Each cycle, write default(idx) to entry idx; idx++.
//   - When idx==DEPTH-1 is written, go to RUN.
//   - ready rises on the cycle after the last write.
//   - INIT lasts exactly DEPTH cycles from reset release.
//  FSM RUN: ready=1. reinit moves to INIT with idx=0, taking effect next cycle.
//  Request acceptance:
//   - rd_en and wr_en are accepted only when ready=1.
//   - While ready=0, requests are dropped silently; rd_valid stays 0; no state change.
//  Read:
//   - Accepted read at cycle N: rd_data, rd_def and rd_valid are set at N+1.
//   - rd_valid is a 1-cycle pulse per accepted read.
//   - With rd_en=0, rd_data and rd_def hold their last value.
//  Write: accepted write at cycle N updates the entry at the end of N and sets defined=1.
//  Read and write to the same address in the same cycle: write-first.
//   rd_data = wr_data and rd_def = 1.
//  reinit together with wr_en or rd_en in RUN:
//   - The request is still accepted (ready=1 that cycle).
//   - INIT then overwrites the entry; the read returns the pre-init contents.
//  reinit during INIT: restart from idx=0.
//  reset_n asserted mid-INIT or mid-RUN: immediate return to reset values, then full INIT.
//  Address range:
//   - Addresses >= DEPTH read as data 0, defined=0, rd_valid=1.
//   - Writes to addresses >= DEPTH are discarded.
//  Storage: flop array, not reset asynchronously; initialised only by INIT.
// STRUCTURE
//  Package pc_lut_pkg:
//   - typedef enum logic {INIT, RUN} lut_state_t
//   - function default_target(idx), returns {defined, 12-bit value}
//   - localparam LUT_MIN_DEPTH = 23
//  Sub-module lut_init_seq: owns the FSM and idx counter.
//   Outputs init_we, init_addr, init_data, ready.
//  Top level: muxes init writes and port writes into the array; holds the read register.
// TESTING
//  1. Release reset_n at cycle 0 (DEPTH=32):
//     -> ready=0 for cycles 0..31, ready=1 at cycle 32; rd_en in cycle 5 gives no rd_valid.
//  2. Read addr 22 -> next cycle rd_data=0x1FF, rd_def=1, rd_valid=1.
//     Read addr 7 -> rd_data=0x000, rd_def=0.
//  3. Write addr 7=0xABC, then read 7 -> rd_data=0xABC, rd_def=1.
//     Back-to-back reads of 0 and 5 -> 0x000, then 0x0FF, on consecutive cycles.
//  4. Same-cycle wr addr 12=0x123 and rd addr 12 -> next cycle rd_data=0x123.
//     A later read of 12 also returns 0x123.
//  5. Pulse reinit after test 3:
//     -> ready=0 for 32 cycles; afterwards read 7 -> 0x000 with rd_def=0,
//        and read 12 -> 0x010.
//  6. Assert reset_n low at INIT cycle 10 for 2 cycles, then release:
//     -> all outputs are 0 during reset; ready rises exactly 32 cycles after release.

Source files
------------

// File: rtl/pc_lut_pkg.sv
// Shared types and default program table for the
// writable fetch-stage PC/constant lookup table.
package pc_lut_pkg;

  typedef enum logic {INIT, RUN} lut_state_t;

  localparam int LUT_MIN_DEPTH = 23;

  // {defined, value}
  function automatic logic [12:0] default_target(
    input int unsigned idx
  );
    logic [12:0] r;
    r = 13'h0000;
    case (idx)
      0:  r = {1'b1, 12'h000};
      1:  r = {1'b1, 12'h001};
      2:  r = {1'b1, 12'h008};
      3:  r = {1'b1, 12'h010};
      4:  r = {1'b1, 12'h011};
      5:  r = {1'b1, 12'h0FF};
      6:  r = {1'b1, 12'h080};
      10: r = {1'b1, 12'h009};
      11: r = {1'b1, 12'h00D};
      12: r = {1'b1, 12'h010};
      13: r = {1'b1, 12'h014};
      14: r = {1'b1, 12'h01D};
      15: r = {1'b1, 12'h025};
      16: r = {1'b1, 12'h032};
      17: r = {1'b1, 12'h034};
      18: r = {1'b1, 12'h041};
      19: r = {1'b1, 12'h043};
      20: r = {1'b1, 12'h046};
      21: r = {1'b1, 12'h049};
      22: r = {1'b1, 12'h1FF};
      default: r = 13'h0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lut_init_seq.sv
// Init sequencer: walks every entry once after reset
// or reinit, emitting default-table writes.
module lut_init_seq
  import pc_lut_pkg::*;
#(
  parameter int D     = 12,
  parameter int A     = 5,
  parameter int DEPTH = 2**A
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         reinit,
  output logic         init_we,
  output logic [A-1:0] init_addr,
  output logic [D-1:0] init_data,
  output logic         init_def,
  output logic         ready
);

  localparam logic [A-1:0] LAST = A'(DEPTH - 1);

  lut_state_t   state;
  logic [A-1:0] idx;
  logic [12:0]  dflt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      idx   <= '0;
    end else if (reinit) begin
      state <= INIT;
      idx   <= '0;
    end else if (state == INIT) begin
      idx <= idx + 1'b1;
      if (idx == LAST)
        state <= RUN;
    end
  end

  assign dflt      = default_target(32'(idx));
  assign init_we   = (state == INIT);
  assign init_addr = idx;
  assign init_data = D'(dflt[11:0]);
  assign init_def  = dflt[12];
  assign ready     = (state == RUN);

endmodule

// File: rtl/pc_target_lut_rf.sv
// Writable PC/constant lookup table with registered
// reads, patch writes and a self-loading default table.
module pc_target_lut_rf
  import pc_lut_pkg::*;
#(
  parameter int D     = 12,
  parameter int A     = 5,
  parameter int DEPTH = 2**A
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         reinit,
  output logic         ready,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_data,
  output logic         rd_def,
  output logic         rd_valid,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data
);

  logic [D-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] def_q;

  logic         init_we;
  logic [A-1:0] init_addr;
  logic [D-1:0] init_data;
  logic         init_def;
  logic         rd_in, wr_in;
  logic         rd_acc, wr_acc;

  lut_init_seq #(.D(D), .A(A), .DEPTH(DEPTH)) u_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .reinit    (reinit),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .init_def  (init_def),
    .ready     (ready)
  );

  if (DEPTH == (1 << A)) begin : g_full
    assign rd_in = 1'b1;
    assign wr_in = 1'b1;
  end else begin : g_part
    assign rd_in = {1'b0, rd_addr} < (A+1)'(DEPTH);
    assign wr_in = {1'b0, wr_addr} < (A+1)'(DEPTH);
  end

  assign rd_acc = rd_en & ready;
  assign wr_acc = wr_en & ready & wr_in;

  // Init and port writes never overlap: ports only act in RUN.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr]   <= init_data;
      def_q[init_addr] <= init_def;
    end else if (wr_acc) begin
      mem[wr_addr]   <= wr_data;
      def_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_def   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        if (!rd_in) begin
          rd_data <= '0;
          rd_def  <= 1'b0;
        end else if (wr_acc && wr_addr == rd_addr) begin
          rd_data <= wr_data;
          rd_def  <= 1'b1;
        end else begin
          rd_data <= mem[rd_addr];
          rd_def  <= def_q[rd_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_target_lut_rf.sv
// Directed bench for pc_target_lut_rf: init timing,
// reads, patches, write-first, reinit and mid-init reset.
module tb_pc_target_lut_rf;

  localparam int D = 12;
  localparam int A = 5;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         reinit = 1'b0;
  logic         ready;
  logic         rd_en = 1'b0;
  logic [A-1:0] rd_addr = '0;
  logic [D-1:0] rd_data;
  logic         rd_def;
  logic         rd_valid;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [D-1:0] wr_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_target_lut_rf #(.D(D), .A(A), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reinit   (reinit),
    .ready    (ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_def   (rd_def),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  typedef struct {
    logic         we;
    logic [A-1:0] wa;
    logic [D-1:0] wd;
    logic         re;
    logic [A-1:0] ra;
    logic         ev;
    logic [D-1:0] ed;
    logic         edef;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; wr_en = 1'b0; reinit = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Expect ready low for exactly DEPTH cycles, high after.
  task automatic expect_init(input string name, input bit poke);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("%s_ready0_c%0d", name, i), 32'(ready), 0);
      idle();
      if (poke && i == 5) begin
        rd_en = 1'b1; rd_addr = 5'd0;
      end
      if (poke && i == DEPTH - 1) begin
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 12'hFFF;
        rd_en = 1'b1; rd_addr = 5'd7;
      end
      tick();
      chk($sformatf("%s_novalid_c%0d", name, i), 32'(rd_valid), 0);
    end
    idle();
    chk({name, "_ready1"}, 32'(ready), 1);
  endtask

  task automatic rd(input string name, input logic [A-1:0] a,
                    input logic [D-1:0] ed, input logic edef);
    idle();
    rd_en = 1'b1; rd_addr = a;
    tick();
    idle();
    chk({name, "_valid"}, 32'(rd_valid), 1);
    chk({name, "_data"}, 32'(rd_data), 32'(ed));
    chk({name, "_def"}, 32'(rd_def), 32'(edef));
  endtask

  function automatic vec_t mk(logic we, logic [A-1:0] wa, logic [D-1:0] wd,
                              logic re, logic [A-1:0] ra, logic ev,
                              logic [D-1:0] ed, logic edef);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.ev = ev; v.ed = ed; v.edef = edef;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(0, 0, 0,       1, 22, 1, 12'h1FF, 1));
    vecs.push_back(mk(0, 0, 0,       1, 7,  1, 12'h000, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0,  0, 12'h000, 0));
    vecs.push_back(mk(1, 7, 12'hABC, 0, 0,  0, 12'h000, 0));
    vecs.push_back(mk(0, 0, 0,       1, 7,  1, 12'hABC, 1));
    vecs.push_back(mk(0, 0, 0,       1, 0,  1, 12'h000, 1));
    vecs.push_back(mk(0, 0, 0,       1, 5,  1, 12'h0FF, 1));
    vecs.push_back(mk(1, 12, 12'h123, 1, 12, 1, 12'h123, 1));
    vecs.push_back(mk(0, 0, 0,       1, 12, 1, 12'h123, 1));
    vecs.push_back(mk(0, 0, 0,       1, 3,  1, 12'h010, 1));
    vecs.push_back(mk(0, 0, 0,       1, 9,  1, 12'h000, 0));
    vecs.push_back(mk(1, 9, 12'h5A5, 1, 10, 1, 12'h009, 1));
    vecs.push_back(mk(0, 0, 0,       1, 9,  1, 12'h5A5, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0,  0, 12'h5A5, 1));
    vecs.push_back(mk(0, 0, 0,       1, 31, 1, 12'h000, 0));

    // Reset state and initial load
    tick(); tick();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_def", 32'(rd_def), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    reset_n = 1'b1;
    expect_init("boot", 1'b1);

    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].re; rd_addr = vecs[i].ra;
      tick();
      idle();
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_def", i), 32'(rd_def), 32'(vecs[i].edef));
    end

    // Reinit with a same-cycle read: returns pre-init contents
    reinit = 1'b1; rd_en = 1'b1; rd_addr = 5'd12;
    tick();
    idle();
    chk("reinit_rd_valid", 32'(rd_valid), 1);
    chk("reinit_rd_data", 32'(rd_data), 32'h123);
    expect_init("reinit", 1'b1);
    rd("post_reinit_7", 5'd7, 12'h000, 1'b0);
    rd("post_reinit_12", 5'd12, 12'h010, 1'b1);
    rd("post_reinit_9", 5'd9, 12'h000, 1'b0);

    // Reset mid-INIT
    rd("pre_rst_5", 5'd5, 12'h0FF, 1'b1);
    reinit = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 0);
    chk("midrst_data", 32'(rd_data), 0);
    chk("midrst_def", 32'(rd_def), 0);
    chk("midrst_valid", 32'(rd_valid), 0);
    tick(); tick();
    chk("midrst_hold_data", 32'(rd_data), 0);
    reset_n = 1'b1;
    expect_init("rerun", 1'b0);
    rd("post_rst_22", 5'd22, 12'h1FF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
